// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: blank-then-show slots per digit, with a
// double-buffered frame that only swaps in at the frame boundary so the display never tears.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   display_q, display_d, pending_q, pending_d;
    logic [NUM_DIGITS-1:0]     display_dp_q, display_dp_d, pending_dp_q, pending_dp_d;
    logic                      pending_valid_q, pending_valid_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     dig_en_q, dig_en_d;
    logic                      frame_done_q, frame_done_d;
    logic                      wrap, accept, commit, show, dp_sel;
    logic [3:0]                nib;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (!ena) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Commit and accept never collide: accept needs an empty pending buffer,
    // in which case the commit has nothing to move.
    always_comb begin
        accept          = load_valid & ~pending_valid_q;
        commit          = wrap & pending_valid_q;
        display_d       = commit ? pending_q : display_q;
        display_dp_d    = commit ? pending_dp_q : display_dp_q;
        pending_d       = accept ? load_data : pending_q;
        pending_dp_d    = accept ? load_dp : pending_dp_q;
        pending_valid_d = accept ? 1'b1 : (commit ? 1'b0 : pending_valid_q);
    end

    // Outputs follow the current state, so they lag the state register by one edge.
    always_comb begin
        nib      = '0;
        dp_sel   = 1'b0;
        dig_en_d = '0;
        show     = (state_q == SHOW);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib         = display_q[4*k +: 4];
                dp_sel      = display_dp_q[k];
                dig_en_d[k] = show;
            end
        end
        seg_d        = show ? hex_decode(nib) : 7'h00;
        dp_d         = show & dp_sel;
        frame_done_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            display_q       <= '0;
            display_dp_q    <= '0;
            pending_q       <= '0;
            pending_dp_q    <= '0;
            pending_valid_q <= 1'b0;
            seg_q           <= '0;
            dp_q            <= 1'b0;
            dig_en_q        <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            display_q       <= display_d;
            display_dp_q    <= display_dp_d;
            pending_q       <= pending_d;
            pending_dp_q    <= pending_dp_d;
            pending_valid_q <= pending_valid_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            dig_en_q        <= dig_en_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign load_ready = ~pending_valid_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position model checked every cycle, plus directed scenarios.
module tb_seg7_scan_ctrl;
    localparam int ND    = 4;
    localparam int PRE   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = ND * PRE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [15:0]   load_data = '0;
    logic [3:0]    load_dp = '0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    dig_en;
    logic          frame_done;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PRE), .BLANK_CYCLES(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dp(load_dp), .seg(seg), .dp(dp), .dig_en(dig_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: position within the frame (-1 = parked); slot = pos/PRE, lit when pos%PRE >= BLK.
    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         m_pos = -1;
    int         m_slot;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_disp_dp = '0, m_pend_dp = '0;
    bit          m_pv = 1'b0, m_acc, m_wrap;
    logic [6:0]  e_seg = '0;
    logic        e_dp = 1'b0, e_fd = 1'b0;
    logic [3:0]  e_dig = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = -1; m_disp = '0; m_disp_dp = '0; m_pend = '0; m_pend_dp = '0; m_pv = 1'b0;
            e_seg = '0; e_dp = 1'b0; e_dig = '0; e_fd = 1'b0;
        end else begin
            if (m_pos >= 0 && (m_pos % PRE) >= BLK) begin
                m_slot = m_pos / PRE;
                e_dig  = 4'(1 << m_slot);
                e_seg  = segtab[m_disp[4*m_slot +: 4]];
                e_dp   = m_disp_dp[m_slot];
            end else begin
                e_dig = '0; e_seg = '0; e_dp = 1'b0;
            end
            m_wrap = ena && (m_pos == FRAME - 1);
            e_fd   = m_wrap;
            m_acc  = load_valid && !m_pv;
            if (m_wrap && m_pv) begin
                m_disp = m_pend; m_disp_dp = m_pend_dp; m_pv = 1'b0;
            end
            if (m_acc) begin
                m_pend = load_data; m_pend_dp = load_dp; m_pv = 1'b1;
            end
            m_pos = !ena ? -1 : ((m_pos < 0) ? 0 : (m_pos + 1) % FRAME);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("seg", 32'(seg), 32'(e_seg));
            chk("dp", 32'(dp), 32'(e_dp));
            chk("dig_en", 32'(dig_en), 32'(e_dig));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("load_ready", 32'(load_ready), 32'(!m_pv));
            chk("dig_en_onehot0", 32'($onehot0(dig_en)), 32'd1);
        end
    end

    task automatic wait_dig(input logic [3:0] d);
        int n = 0;
        while (dig_en !== d && n < 80) begin @(negedge clk); n++; end
        chk("wait_dig", 32'(dig_en), 32'(d));
    endtask

    task automatic wait_fd();
        int n = 0;
        while (frame_done !== 1'b1 && n < 80) begin @(negedge clk); n++; end
        chk("wait_frame_done", 32'(frame_done), 32'd1);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        load_valid = 1'b1; load_data = d; load_dp = p;
        @(negedge clk);
        load_valid = 1'b0;
        chk("load_taken", 32'(load_ready), 32'd0);
    endtask

    int cnt, len;

    initial begin
        rst_n = 1'b0;
        // Scenario 1: reset state, first slot timing
        repeat (2) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_dig_en", 32'(dig_en), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        cnt = 0;
        while (dig_en == 4'b0000 && cnt < 20) begin @(negedge clk); cnt++; end
        chk("first_show_latency", 32'(cnt), 32'd4);
        chk("first_dig", 32'(dig_en), 32'b0001);
        chk("first_seg", 32'(seg), 32'h3F);
        len = 0;
        while (dig_en == 4'b0001 && len < 20) begin len++; @(negedge clk); end
        chk("show_len", 32'(len), 32'd6);
        len = 0;
        while (dig_en == 4'b0000 && len < 20) begin len++; @(negedge clk); end
        chk("blank_len", 32'(len), 32'd2);
        chk("second_dig", 32'(dig_en), 32'b0010);

        // Scenario 2: single load commits at the boundary
        load(16'hF8A1, 4'b0000);
        wait_fd();
        chk("ready_after_commit", 32'(load_ready), 32'd1);
        wait_dig(4'b0001); chk("f8a1_d0", 32'(seg), 32'h06);
        wait_dig(4'b0010); chk("f8a1_d1", 32'(seg), 32'h77);
        wait_dig(4'b0100); chk("f8a1_d2", 32'(seg), 32'h7F);
        wait_dig(4'b1000); chk("f8a1_d3", 32'(seg), 32'h71);

        // Scenario 3: back-to-back loads, second stalls until the boundary
        load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'b0101;
        @(negedge clk);
        chk("bb_first_taken", 32'(load_ready), 32'd0);
        load_data = 16'h5678; load_dp = 4'b1010;
        wait_fd();
        chk("bb_ready_at_fd", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("bb_second_taken", 32'(load_ready), 32'd0);
        wait_dig(4'b0001); chk("bb1_d0", 32'(seg), 32'h66); chk("bb1_dp0", 32'(dp), 32'd1);
        wait_dig(4'b0010); chk("bb1_d1", 32'(seg), 32'h4F); chk("bb1_dp1", 32'(dp), 32'd0);
        wait_fd();
        wait_dig(4'b0001); chk("bb2_d0", 32'(seg), 32'h7F); chk("bb2_dp0", 32'(dp), 32'd0);
        wait_dig(4'b0010); chk("bb2_d1", 32'(seg), 32'h07); chk("bb2_dp1", 32'(dp), 32'd1);

        // Scenario 4: drop ena mid-SHOW of digit 2, then restart
        wait_dig(4'b0100);
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk("ena_off_lag", 32'(dig_en), 32'b0100);
        @(negedge clk);
        chk("ena_off_dig", 32'(dig_en), 32'd0);
        chk("ena_off_seg", 32'(seg), 32'd0);
        repeat (10) @(negedge clk);
        ena = 1'b1;
        cnt = 0;
        while (dig_en == 4'b0000 && cnt < 20) begin @(negedge clk); cnt++; end
        chk("restart_latency", 32'(cnt), 32'd4);
        chk("restart_dig", 32'(dig_en), 32'b0001);
        chk("restart_seg", 32'(seg), 32'h7F);

        // Scenario 5: frame_done period
        wait_fd();
        for (int r = 0; r < 2; r++) begin
            cnt = 0;
            @(negedge clk);
            cnt++;
            while (frame_done !== 1'b1 && cnt < 80) begin @(negedge clk); cnt++; end
            chk("fd_period", 32'(cnt), 32'd32);
        end

        // Scenario 6: async reset mid-frame with a pending load
        wait_dig(4'b0010);
        load(16'hABCD, 4'b1111);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_seg", 32'(seg), 32'd0);
        chk("async_rst_dig", 32'(dig_en), 32'd0);
        chk("async_rst_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_dig(4'b0001); chk("post_rst_d0", 32'(seg), 32'h3F);
        wait_fd();
        wait_dig(4'b0001); chk("post_rst_no_commit", 32'(seg), 32'h3F);
        chk("post_rst_dp", 32'(dp), 32'd0);
        repeat (4) @(negedge clk);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
